// File: rtl/la_pkg.sv
// Shared types for the logic-analyser capture path.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_WR,
    EV_ARM,
    EV_DONE
  } cap_ev_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sampling-side control bus of the capture controller; master is the
// sample/trigger source, slave is capture_ctrl.
interface capture_ctrl_if #(
  parameter int LOG2 = 9
);
  logic            wrt_smpl;
  logic            run;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            clr_capture;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            set_armed;
  logic            armed;
  logic            set_capture_done;
  logic            capture_done;
  logic [LOG2-1:0] addr_ptr;

  modport master (
    output wrt_smpl, run, triggered, trig_pos, clr_capture,
    input  we, waddr, set_armed, armed, set_capture_done, capture_done, addr_ptr
  );

  modport slave (
    input  wrt_smpl, run, triggered, trig_pos, clr_capture,
    output we, waddr, set_armed, armed, set_capture_done, capture_done, addr_ptr
  );
endinterface

// File: rtl/capture_ctrl_wrap_cntr.sv
// Modulo-ENTRIES address counter; clr has priority over en, nxt is the
// combinational successor of cnt.
module wrap_cntr #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [LOG2-1:0] cnt,
  output logic [LOG2-1:0] nxt
);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  assign nxt = (cnt == LAST) ? '0 : cnt + LOG2'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= nxt;
    end
  end
endmodule

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: pre-trigger fill, arm, post-trigger count.
// we is combinational with wrt_smpl; all other outputs are registered (1 clk).
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  capture_ctrl_if.slave bus
);
  localparam logic [LOG2-1:0] TP_MAX  = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   DEPTH_W = (LOG2 + 1)'(ENTRIES);

  cap_state_t      state;
  logic [LOG2-1:0] smpl_cnt;
  logic [LOG2-1:0] trig_cnt;
  logic [LOG2-1:0] tp;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] waddr_nxt;
  logic [LOG2:0]   smpl_inc;
  logic [LOG2:0]   fill_target;
  logic [LOG2-1:0] trig_inc;
  logic            capturing;
  logic            armed_r;
  logic            set_armed_r;
  logic            done_r;
  logic            set_done_r;
  logic [LOG2-1:0] addr_ptr_r;

  // Pre-trigger depth can equal ENTRIES (tp == 0), hence the extra bit.
  assign smpl_inc    = {1'b0, smpl_cnt} + (LOG2 + 1)'(1);
  assign fill_target = DEPTH_W - {1'b0, tp};
  assign trig_inc    = trig_cnt + LOG2'(1);
  assign capturing   = (state == FILL) || (state == ARMED) || (state == POST);

  assign bus.we               = bus.wrt_smpl & capturing;
  assign bus.waddr            = waddr;
  assign bus.armed            = armed_r;
  assign bus.set_armed        = set_armed_r;
  assign bus.capture_done     = done_r;
  assign bus.set_capture_done = set_done_r;
  assign bus.addr_ptr         = addr_ptr_r;

  wrap_cntr #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) && bus.run),
    .en    (bus.we),
    .cnt   (waddr),
    .nxt   (waddr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      smpl_cnt    <= '0;
      trig_cnt    <= '0;
      tp          <= '0;
      armed_r     <= 1'b0;
      set_armed_r <= 1'b0;
      done_r      <= 1'b0;
      set_done_r  <= 1'b0;
      addr_ptr_r  <= '0;
    end else begin
      set_armed_r <= 1'b0;
      set_done_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            state    <= FILL;
            smpl_cnt <= '0;
            trig_cnt <= '0;
            tp       <= (bus.trig_pos > TP_MAX) ? TP_MAX : bus.trig_pos;
          end
        end
        FILL: begin
          if (!bus.run) begin
            state   <= IDLE;
            armed_r <= 1'b0;
          end else if (bus.wrt_smpl) begin
            smpl_cnt <= smpl_inc[LOG2-1:0];
            if (smpl_inc == fill_target) begin
              state       <= ARMED;
              set_armed_r <= 1'b1;
              armed_r     <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (!bus.run) begin
            state   <= IDLE;
            armed_r <= 1'b0;
          end else if (bus.triggered) begin
            trig_cnt <= '0;
            if (tp == '0) begin
              state      <= DONE;
              set_done_r <= 1'b1;
              done_r     <= 1'b1;
              armed_r    <= 1'b0;
              addr_ptr_r <= bus.we ? waddr_nxt : waddr;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (!bus.run) begin
            state   <= IDLE;
            armed_r <= 1'b0;
          end else if (bus.wrt_smpl) begin
            trig_cnt <= trig_inc;
            if (trig_inc == tp) begin
              state      <= DONE;
              set_done_r <= 1'b1;
              done_r     <= 1'b1;
              armed_r    <= 1'b0;
              addr_ptr_r <= waddr_nxt;
            end
          end
        end
        DONE: begin
          if (bus.clr_capture) begin
            state  <= IDLE;
            done_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: stimulus queues expected events, a negedge
// monitor pops and compares every we / set_armed / set_capture_done it sees.
module tb_capture_ctrl;
  import la_pkg::*;

  localparam int N = 384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_ctrl_if #(.LOG2(9)) bus ();

  capture_ctrl #(
    .ENTRIES (N),
    .LOG2    (9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    cap_ev_t kind;
    int      val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input cap_ev_t kind, input logic [31:0] val, input string name);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event %s val=%0d, expected nothing (t=%0t)",
               name, kind.name(), val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || val !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %s val=%0d, expected %s val=%0d (t=%0t)",
                 name, kind.name(), val, e.kind.name(), e.val, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.set_armed)        pop_cmp(EV_ARM, 32'(bus.armed), "set_armed");
      if (bus.set_capture_done) pop_cmp(EV_DONE, 32'(bus.addr_ptr), "capture_done_addr_ptr");
      if (bus.we)               pop_cmp(EV_WR, 32'(bus.waddr), "we_waddr");
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input cap_ev_t k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // One sample strobe; 'after' is the event expected on the following cycle.
  task automatic write(input bit trig, input int addr, input int gap,
                       input cap_ev_t after = EV_NONE, input int after_val = 0);
    bus.wrt_smpl  = 1'b1;
    bus.triggered = trig;
    expect_ev(EV_WR, addr);
    if (after != EV_NONE) expect_ev(after, after_val);
    tick(1);
    bus.wrt_smpl  = 1'b0;
    bus.triggered = 1'b0;
    tick(gap);
  endtask

  task automatic pulse_clr();
    bus.clr_capture = 1'b1;
    tick(1);
    bus.clr_capture = 1'b0;
  endtask

  initial begin
    bus.wrt_smpl    = 1'b0;
    bus.run         = 1'b0;
    bus.triggered   = 1'b0;
    bus.trig_pos    = '0;
    bus.clr_capture = 1'b0;
    tick(2);
    check("rst_we", bus.we, 0);
    check("rst_waddr", bus.waddr, 0);
    check("rst_armed", bus.armed, 0);
    check("rst_capture_done", bus.capture_done, 0);
    check("rst_addr_ptr", bus.addr_ptr, 0);
    rst_n = 1'b1;
    tick(1);

    // trig_pos=128, write every 4 clk, trigger pulsed in FILL then at write 300.
    bus.trig_pos = 9'd128;
    bus.run      = 1'b1;
    tick(1);
    for (int k = 1; k <= 256; k++) begin
      write(k == 10, k - 1, 3, (k == 256) ? EV_ARM : EV_NONE, 1);
      if (k == 255) check("fill_not_armed", bus.armed, 0);
    end
    check("armed_after_256", bus.armed, 1);
    for (int k = 257; k <= 300; k++) write(k == 300, (k - 1) % N, 3);
    check("armed_in_post", bus.armed, 1);
    for (int k = 301; k <= 428; k++)
      write(1'b0, (k - 1) % N, 3, (k == 428) ? EV_DONE : EV_NONE, 44);
    check("done_level", bus.capture_done, 1);
    check("done_armed_low", bus.armed, 0);
    check("done_waddr", bus.waddr, 44);
    bus.wrt_smpl  = 1'b1;
    bus.triggered = 1'b1;
    bus.run       = 1'b0;
    tick(2);
    bus.wrt_smpl  = 1'b0;
    bus.triggered = 1'b0;
    tick(1);
    check("done_waddr_frozen", bus.waddr, 44);
    check("done_ignores_run", bus.capture_done, 1);
    bus.run = 1'b1;

    // trig_pos=0: full 384-write fill, trigger without a write.
    bus.trig_pos = 9'd0;
    pulse_clr();
    check("clr_releases_done", bus.capture_done, 0);
    tick(1);
    for (int k = 1; k <= N; k++) write(1'b0, k - 1, 1, (k == N) ? EV_ARM : EV_NONE, 1);
    check("tp0_armed", bus.armed, 1);
    check("tp0_waddr_wrapped", bus.waddr, 0);
    bus.triggered = 1'b1;
    expect_ev(EV_DONE, 0);
    tick(1);
    bus.triggered = 1'b0;
    tick(2);
    check("tp0_done", bus.capture_done, 1);

    // trig_pos=500 clamps to 383; a later trig_pos change is ignored.
    bus.trig_pos = 9'd500;
    pulse_clr();
    tick(1);
    bus.trig_pos = 9'd5;
    write(1'b0, 0, 1, EV_ARM, 1);
    check("clamp_armed_1_write", bus.armed, 1);
    write(1'b1, 1, 1);
    for (int k = 1; k <= 383; k++)
      write(1'b0, (1 + k) % N, 1, (k == 383) ? EV_DONE : EV_NONE, 1);
    check("clamp_done", bus.capture_done, 1);

    // trig_pos=4: clr in FILL ignored, then run dropped in POST.
    bus.trig_pos = 9'd4;
    pulse_clr();
    tick(1);
    for (int k = 1; k <= 380; k++) begin
      if (k == 50) pulse_clr();
      write(1'b0, k - 1, 1, (k == 380) ? EV_ARM : EV_NONE, 1);
    end
    check("tp4_armed", bus.armed, 1);
    write(1'b1, 380, 1);
    write(1'b0, 381, 1);
    write(1'b0, 382, 1);
    bus.run = 1'b0;
    tick(1);
    check("abort_armed", bus.armed, 0);
    check("abort_no_done", bus.capture_done, 0);
    bus.wrt_smpl = 1'b1;
    tick(1);
    bus.wrt_smpl = 1'b0;
    tick(2);

    // Asynchronous reset while ARMED.
    bus.trig_pos = 9'd383;
    bus.run      = 1'b1;
    tick(1);
    write(1'b0, 0, 1, EV_ARM, 1);
    check("pre_rst_waddr", bus.waddr, 1);
    bus.wrt_smpl = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_armed", bus.armed, 0);
    check("arst_waddr", bus.waddr, 0);
    check("arst_we", bus.we, 0);
    check("arst_addr_ptr", bus.addr_ptr, 0);
    check("arst_set_armed", bus.set_armed, 0);
    check("arst_capture_done", bus.capture_done, 0);
    check("arst_set_capture_done", bus.set_capture_done, 0);
    bus.wrt_smpl = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    write(1'b0, 0, 1, EV_ARM, 1);
    bus.run = 1'b0;
    tick(3);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 384, meaning RAM depth per channel (12288 on DE-0).
REQ-002 SHALL have parameter LOG2, default 9, meaning address width; ENTRIES <= 2^LOG2.
REQ-003 SHALL use one clock and an asynchronous active-low reset: ports clk and rst_n.
REQ-004 clk  input  1  100MHz system clock.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 wrt_smpl  input  1  one-clk strobe; a decimated sample is valid this cycle.
REQ-007 run  input  1  level; capture enabled (from cmd_cfg).
REQ-008 triggered  input  1  combined channel/protocol trigger, sampled every clk.
REQ-009 trig_pos  input  LOG2  post-trigger sample count.
REQ-010 clr_capture  input  1  pulse; host finished dump, release DONE.
REQ-011 we  output  1  write enable to all channel RAMs.
REQ-012 waddr  output  LOG2  write address to all RAMs.
REQ-013 set_armed  output  1  one-clk pulse when pre-trigger fill completes.
REQ-014 armed  output  1  level; trigger accepted.
REQ-015 set_capture_done  output  1  one-clk pulse on capture completion.
REQ-016 capture_done  output  1  level; RAM holds a complete capture.
REQ-017 addr_ptr  output  LOG2  address of oldest sample (dump start).

Function
REQ-018 States IDLE, FILL, ARMED, POST, DONE; reset -> IDLE.
REQ-019 IDLE: run=1 -> FILL next clk; on transition waddr<=0, smpl_cnt<=0, trig_cnt<=0, tp<=min(trig_pos, ENTRIES-1) latched.
REQ-020 we = wrt_smpl & state in {FILL, ARMED, POST}, combinational, same cycle as wrt_smpl.
REQ-021 Each write: waddr increments next clk, wraps ENTRIES-1 -> 0.
REQ-022 FILL: each write increments smpl_cnt; the write making smpl_cnt == ENTRIES-tp -> ARMED, set_armed pulses one clk, armed<=1.
REQ-023 triggered ignored in IDLE and FILL.
REQ-024 ARMED: triggered=1 -> POST, trig_cnt<=0; a write in the trigger cycle is written and counts as pre-trigger.
REQ-025 ARMED: writes continue circularly; no count limit.
REQ-026 POST: each write increments trig_cnt; the write making trig_cnt == tp -> DONE.
REQ-027 tp == 0: ARMED -> DONE directly on trigger, no post-trigger writes.
REQ-028 DONE entry: set_capture_done pulses one clk; capture_done<=1; armed<=0; addr_ptr<=waddr (already advanced past last write).
REQ-029 DONE: we=0; waddr frozen; trigger and wrt_smpl ignored; clr_capture -> IDLE, capture_done<=0.
REQ-030 run=0 in FILL/ARMED/POST: abort to IDLE next clk, armed<=0, no set_capture_done.
REQ-031 clr_capture outside DONE: no effect; run ignored in DONE.
REQ-032 trig_pos changes after the IDLE -> FILL transition do not affect the current capture.

Reset
REQ-033 rst_n low asynchronously forces IDLE, waddr=0, addr_ptr=0, counters=0, we=0, armed=0, set_armed=0, capture_done=0, set_capture_done=0, including mid-capture.

Structure
REQ-034 State enum cap_state_t SHALL live in shared package la_pkg.
REQ-035 One sub-module wrap_cntr (LOG2-bit counter, clr, en, wrap at ENTRIES-1) SHALL implement waddr.
REQ-036 smpl_cnt and trig_cnt SHALL be LOG2 bits; all outputs registered except we.

Verification (ENTRIES=384, LOG2=9)
REQ-037 trig_pos=128, run=1, wrt_smpl every 4 clk -> set_armed after 256th write, armed=1.
REQ-038 Same, trigger at write 300 -> 128 post writes; set_capture_done once; addr_ptr == (300+128) mod 384 = 44; we=0 after.
REQ-039 trig_pos=0, trigger once armed -> DONE with zero post-trigger writes; trig_pos=500 -> clamped to 383, armed after 1 write.
REQ-040 Trigger pulsed during FILL -> ignored, state stays FILL; wrt_smpl and trigger in same ARMED cycle -> sample counted pre-trigger.
REQ-041 run dropped in POST -> IDLE, no set_capture_done; rst_n low mid-ARMED -> all outputs 0 immediately.
REQ-042 clr_capture in DONE -> IDLE, capture_done=0; new run restarts at waddr=0.
